// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard/stall controller for the 5-stage RV32I pipeline. It drives the
// load/flush enables of the PC and the four pipeline registers and resolves
// three hazard classes in priority order:
//   1. memory-response stall (fetch or data access still outstanding)
//   2. EX-stage redirect (taken branch/jump) -> flush IF/ID and ID/EX
//   3. load-use dependency -> hold PC and IF/ID and insert one bubble in ID/EX
// One-cycle memory responses that arrive while the pipeline is frozen are
// latched in done flags. The flags gate the request to memory so a finished
// access is never reissued.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   id_rs1_addr/id_rs2_addr   source registers of the ID instruction
//   id_uses_rs1/id_uses_rs2   ID instruction actually reads rs1/rs2
//   ex_rd, ex_mem_read        destination and load flag of the EX instruction
//   ex_redirect               EX resolved a taken branch/jump
//   imem_read, imem_resp      fetch request / one-cycle fetch response
//   dmem_req, dmem_resp       data request / one-cycle data response
//   load_*                    register load enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   flush_if_id, flush_id_ex  register flushes (flush overrides load)
//   imem_gate, dmem_gate      0 masks the request once its response is latched
//   stall_cycles, bubble_count, flush_count   saturating performance counters
//   mem_timeout               sticky watchdog error for a memory stall that never ends
module pipeline_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             imem_gate,
    output logic             dmem_gate,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_BUBBLE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_imem_done;
    logic              r_dmem_done;
    logic [WD_W-1:0]   r_wd;
    logic [WD_W-1:0]   w_wd_cur;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_bubble_count;
    logic [CNT_W-1:0]  r_flush_count;
    logic              r_mem_timeout;

    logic              w_mem_stall;
    logic              w_advance;
    logic              w_load_use;
    logic              w_redirect_take;
    logic              w_bubble_take;

    // A latched response counts as complete, so only unanswered requests stall.
    assign w_mem_stall = (imem_read & ~imem_resp & ~r_imem_done)
                       | (dmem_req  & ~dmem_resp & ~r_dmem_done);
    assign w_advance   = ~w_mem_stall;

    assign w_load_use  = ex_mem_read & (ex_rd != 5'd0)
                       & ((id_uses_rs1 & (ex_rd == id_rs1_addr))
                        | (id_uses_rs2 & (ex_rd == id_rs2_addr)));

    // A redirect makes the ID instruction wrong-path, so it masks load-use.
    assign w_redirect_take = w_advance & ex_redirect;
    assign w_bubble_take   = w_advance & ~ex_redirect & w_load_use;

    assign imem_gate    = ~r_imem_done;
    assign dmem_gate    = ~r_dmem_done;
    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;
    assign flush_count  = r_flush_count;
    assign mem_timeout  = r_mem_timeout;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = ST_RUN;
        if (w_mem_stall) begin
            w_next_state = ST_MEM_WAIT;
        end else if (w_load_use && !ex_redirect) begin
            w_next_state = ST_BUBBLE;
        end else begin
            w_next_state = ST_RUN;
        end
    end

    // FSM outputs: load/flush enables in hazard priority order; held at pass-through during reset.
    always_comb begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (!rst) begin
            load_pc = 1'b1;
        end else if (w_mem_stall) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (w_load_use) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
        end else begin
            flush_id_ex = 1'b0;
        end
    end

    // Response latches: set on a response while frozen, cleared whenever the pipeline advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_imem_done <= 1'b0;
            r_dmem_done <= 1'b0;
        end else if (w_advance) begin
            r_imem_done <= 1'b0;
            r_dmem_done <= 1'b0;
        end else begin
            r_imem_done <= r_imem_done | imem_resp;
            r_dmem_done <= r_dmem_done | dmem_resp;
        end
    end

    // Watchdog count of the current stall run; restarts whenever the FSM was not waiting.
    always_comb begin
        if (r_state == ST_MEM_WAIT) begin
            w_wd_cur = r_wd;
        end else begin
            w_wd_cur = {WD_W{1'b0}};
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd          <= {WD_W{1'b0}};
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_mem_stall && (w_wd_cur != WD_LAST)) begin
                r_wd <= w_wd_cur + WD_W'(1);
            end else if (w_mem_stall) begin
                r_wd <= w_wd_cur;
            end else begin
                r_wd <= {WD_W{1'b0}};
            end
            if ((TIMEOUT != 0) && w_mem_stall && (w_wd_cur == WD_LAST)) begin
                r_mem_timeout <= 1'b1;
            end else begin
                r_mem_timeout <= r_mem_timeout;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= {CNT_W{1'b0}};
            r_bubble_count <= {CNT_W{1'b0}};
            r_flush_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_mem_stall && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (w_bubble_take && (r_bubble_count != CNT_MAX)) begin
                r_bubble_count <= r_bubble_count + CNT_W'(1);
            end else begin
                r_bubble_count <= r_bubble_count;
            end
            if (w_redirect_take && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;

    logic clk;
    logic rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic imem_read, imem_resp, dmem_req, dmem_resp;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex, imem_gate, dmem_gate, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, bubble_count, flush_count;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .imem_gate(imem_gate), .dmem_gate(dmem_gate),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count),
        .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [4:0] loads   = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    wire [1:0] flushes = {flush_if_id, flush_id_ex};
    wire [1:0] gates   = {imem_gate, dmem_gate};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
        imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        // during reset an unanswered fetch must not stall
        imem_read = 1'b1;
        #12;
        chk("rst_loads", loads, 32'h1F);
        chk("rst_flush", flushes, 32'h0);
        chk("rst_gates", gates, 32'h3);
        chk("rst_stall", stall_cycles, 32'h0);
        chk("rst_timeout", mem_timeout, 32'h0);
        rst = 1'b1;
        imem_resp = 1'b1;

        // 1: fetch answered every cycle, no hazards
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t1_loads", loads, 32'h1F);
            chk("t1_flush", flushes, 32'h0);
            step();
        end
        chk("t1_stall", stall_cycles, 32'h0);
        chk("t1_bubble", bubble_count, 32'h0);
        chk("t1_flushcnt", flush_count, 32'h0);

        // 2: load-use on rs1
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
        #1;
        chk("t2_lu_loads", loads, 32'h07);
        chk("t2_lu_flush", flushes, 32'h1);
        step();
        ex_mem_read = 1'b0;  // bubble now in EX
        #1;
        chk("t2_after_loads", loads, 32'h1F);
        chk("t2_after_flush", flushes, 32'h0);
        chk("t2_bubble1", bubble_count, 32'h1);
        // load to x0 never creates a dependency
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1_addr = 5'd0;
        #1;
        chk("t2_x0_loads", loads, 32'h1F);
        step();
        chk("t2_x0_bubble", bubble_count, 32'h1);
        // dependency via rs2 only
        ex_rd = 5'd9; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b1; id_rs2_addr = 5'd9;
        #1;
        chk("t2_rs2_loads", loads, 32'h07);
        step();
        chk("t2_bubble2", bubble_count, 32'h2);

        // 3: redirect masks load-use
        do_reset();
        imem_read = 1'b1; imem_resp = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
        ex_redirect = 1'b1;
        #1;
        chk("t3_loads", loads, 32'h1F);
        chk("t3_flush", flushes, 32'h3);
        step();
        chk("t3_flushcnt", flush_count, 32'h1);
        chk("t3_bubble", bubble_count, 32'h0);

        // 4: dmem_resp at cycle 3, imem_resp at cycle 6
        do_reset();
        imem_read = 1'b1; dmem_req = 1'b1;
        for (int c = 0; c < 7; c++) begin
            dmem_resp = (c == 3);
            imem_resp = (c == 6);
            #1;
            chk("t4_loads", loads, (c < 6) ? 32'h0 : 32'h1F);
            chk("t4_dgate", dmem_gate, (c >= 4) ? 32'h0 : 32'h1);
            chk("t4_igate", imem_gate, 32'h1);
            step();
        end
        imem_resp = 1'b0; dmem_resp = 1'b0; imem_read = 1'b0; dmem_req = 1'b0;
        #1;
        chk("t4_gates_c7", gates, 32'h3);
        chk("t4_stall", stall_cycles, 32'h6);

        // 5: watchdog with TIMEOUT=8
        do_reset();
        imem_read = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t5_loads", loads, 32'h0);
            chk("t5_timeout_pre", mem_timeout, 32'h0);
            step();
        end
        chk("t5_timeout_set", mem_timeout, 32'h1);
        imem_resp = 1'b1;
        #1;
        chk("t5_resp_loads", loads, 32'h1F);
        step();
        imem_resp = 1'b0;
        chk("t5_timeout_sticky", mem_timeout, 32'h1);
        chk("t5_stall8", stall_cycles, 32'h8);
        // keep stalling past the 4-bit counter limit
        for (int c = 0; c < 10; c++) step();
        chk("t5_stall_sat", stall_cycles, 32'hF);

        // 6: reset mid-stall with a latched data response
        dmem_req = 1'b1; dmem_resp = 1'b1;
        step();
        dmem_resp = 1'b0;
        #1;
        chk("t6_dgate_pre", dmem_gate, 32'h0);
        chk("t6_loads_pre", loads, 32'h0);
        rst = 1'b0;
        #1;
        chk("t6_dgate_rst", dmem_gate, 32'h1);
        chk("t6_loads_rst", loads, 32'h1F);
        chk("t6_stall_rst", stall_cycles, 32'h0);
        chk("t6_timeout_rst", mem_timeout, 32'h0);
        clear_inputs();
        step();
        rst = 1'b1;
        #1;
        chk("t6_run_loads", loads, 32'h1F);
        step();
        chk("t6_stall_after", stall_cycles, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
